// File: rtl/rotary_emulator.sv
// rtl/rotary_emulator.sv - quadrature rotary encoder emulator producing Gray-code detents and button clicks
// Outputs are registered from the current state, so every waveform lags the accept edge by one cycle.
module rotary_emulator #(
    parameter int PHASE_CYC = 64,
    parameter int GAP_CYC   = 512
) (
    input  logic       Fg_clk,
    input  logic       Resetn,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_dir,
    input  logic [7:0] cmd_count,
    input  logic       cmd_button,
    output logic       Rot_A,
    output logic       Rot_B,
    output logic       Rot_C,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE,
        PH1,
        PH2,
        PH3,
        PH4,
        GAP,
        CLICK
    } state_t;

    localparam logic [15:0] PH_LOAD  = 16'(PHASE_CYC - 1);
    localparam logic [15:0] GAP_LOAD = 16'(GAP_CYC - 1);

    state_t      state;
    logic [15:0] tmr;
    logic [7:0]  remain;
    logic        dir;
    logic        ready_q;
    logic        done_pend;
    logic        accept;
    logic [1:0]  ab_code;

    // ready_q lags the state by one cycle so cmd_ready rises together with done
    assign cmd_ready = ready_q && (state == IDLE);
    assign busy      = ~cmd_ready;
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        ab_code = 2'b11;
        case (state)
            PH1:     ab_code = dir ? 2'b10 : 2'b01;
            PH2:     ab_code = 2'b00;
            PH3:     ab_code = dir ? 2'b01 : 2'b10;
            default: ab_code = 2'b11;
        endcase
    end

    always_ff @(posedge Fg_clk or negedge Resetn) begin
        if (!Resetn) begin
            state     <= IDLE;
            tmr       <= '0;
            remain    <= '0;
            dir       <= 1'b0;
            ready_q   <= 1'b1;
            done_pend <= 1'b0;
            Rot_A     <= 1'b1;
            Rot_B     <= 1'b1;
            Rot_C     <= 1'b0;
            done      <= 1'b0;
        end else begin
            done_pend      <= 1'b0;
            done           <= done_pend;
            ready_q        <= (state == IDLE) && !accept;
            {Rot_A, Rot_B} <= ab_code;
            Rot_C          <= (state == CLICK);

            case (state)
                IDLE: begin
                    if (accept) begin
                        if (cmd_button) begin
                            state <= CLICK;
                        end else if (cmd_count == 8'd0) begin
                            done_pend <= 1'b1;
                        end else begin
                            remain <= cmd_count;
                            dir    <= cmd_dir;
                            tmr    <= PH_LOAD;
                            state  <= PH1;
                        end
                    end
                end
                PH1, PH2, PH3, PH4: begin
                    if (tmr == 16'd0) begin
                        case (state)
                            PH1:     state <= PH2;
                            PH2:     state <= PH3;
                            PH3:     state <= PH4;
                            default: state <= GAP;
                        endcase
                        tmr <= (state == PH4) ? GAP_LOAD : PH_LOAD;
                    end else begin
                        tmr <= tmr - 16'd1;
                    end
                end
                GAP: begin
                    if (tmr == 16'd0) begin
                        remain <= remain - 8'd1;
                        if (remain == 8'd1) begin
                            state     <= IDLE;
                            done_pend <= 1'b1;
                        end else begin
                            state <= PH1;
                            tmr   <= PH_LOAD;
                        end
                    end else begin
                        tmr <= tmr - 16'd1;
                    end
                end
                CLICK: begin
                    // a click is followed by exactly one gap, then done
                    remain <= 8'd1;
                    tmr    <= GAP_LOAD;
                    state  <= GAP;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
